// File: rtl/cpu_axi4_bridge.sv
// cpu_axi4_bridge
//   Converts single-beat CPU load/store requests into AXI4 single-beat bursts
//   (LEN=0, SIZE=4 bytes, INCR) on one master port, one transaction at a time.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   req_*                 CPU request channel (valid/ready, we, addr, wdata, wstrb)
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  completion payload, held until the next completion
//   busy                  high while a transaction is in flight
//   M2_AXI4_AW*/W*/B*     AXI4 write address, write data and write response channels
//   M2_AXI4_AR*/R*        AXI4 read address and read data channels
//
// Misaligned requests (addr[1:0] != 0) complete with err=1, rdata=0 and never
// reach the bus. Only DATA_WIDTH = 32 is supported.
module cpu_axi4_bridge #(
    parameter int unsigned AXI4_ID_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned AXI_ID        = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // CPU side
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    input  logic [DATA_WIDTH/8-1:0]    req_wstrb,
    output logic                       resp_valid,
    output logic [DATA_WIDTH-1:0]      resp_rdata,
    output logic                       resp_err,
    output logic                       busy,
    // AXI4 write address
    output logic [AXI4_ID_WIDTH-1:0]   M2_AXI4_AWID,
    output logic [ADDR_WIDTH-1:0]      M2_AXI4_AWADDR,
    output logic [7:0]                 M2_AXI4_AWLEN,
    output logic [2:0]                 M2_AXI4_AWSIZE,
    output logic [1:0]                 M2_AXI4_AWBURST,
    output logic                       M2_AXI4_AWVALID,
    input  logic                       M2_AXI4_AWREADY,
    // AXI4 write data
    output logic [DATA_WIDTH-1:0]      M2_AXI4_WDATA,
    output logic [DATA_WIDTH/8-1:0]    M2_AXI4_WSTRB,
    output logic                       M2_AXI4_WLAST,
    output logic                       M2_AXI4_WVALID,
    input  logic                       M2_AXI4_WREADY,
    // AXI4 write response
    input  logic [AXI4_ID_WIDTH-1:0]   M2_AXI4_BID,
    input  logic [1:0]                 M2_AXI4_BRESP,
    input  logic                       M2_AXI4_BVALID,
    output logic                       M2_AXI4_BREADY,
    // AXI4 read address
    output logic [AXI4_ID_WIDTH-1:0]   M2_AXI4_ARID,
    output logic [ADDR_WIDTH-1:0]      M2_AXI4_ARADDR,
    output logic [7:0]                 M2_AXI4_ARLEN,
    output logic [2:0]                 M2_AXI4_ARSIZE,
    output logic [1:0]                 M2_AXI4_ARBURST,
    output logic                       M2_AXI4_ARVALID,
    input  logic                       M2_AXI4_ARREADY,
    // AXI4 read data
    input  logic [AXI4_ID_WIDTH-1:0]   M2_AXI4_RID,
    input  logic [DATA_WIDTH-1:0]      M2_AXI4_RDATA,
    input  logic [1:0]                 M2_AXI4_RRESP,
    input  logic                       M2_AXI4_RLAST,
    input  logic                       M2_AXI4_RVALID,
    output logic                       M2_AXI4_RREADY
);

    localparam logic [AXI4_ID_WIDTH-1:0] IdVal = AXI4_ID_WIDTH'(AXI_ID);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdAddr,
        StRdData,
        StDone
    } state_e;

    state_e                    state_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;
    logic                      req_ready_q;
    logic                      busy_q;
    logic                      awvalid_q;
    logic                      wvalid_q;
    logic                      bready_q;
    logic                      arvalid_q;
    logic                      rready_q;
    logic                      resp_valid_q;
    logic                      resp_err_q;
    logic [DATA_WIDTH-1:0]     resp_rdata_q;

    // A channel is finished once its valid is already down or handshakes this cycle;
    // this lets AW and W complete in either order or together.
    logic aw_clear;
    logic w_clear;
    assign aw_clear = ~awvalid_q | M2_AXI4_AWREADY;
    assign w_clear  = ~wvalid_q  | M2_AXI4_WREADY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        wstrb_q     <= req_wstrb;
                        if (req_addr[1:0] != 2'b00) begin
                            state_q      <= StDone;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_we) begin
                            state_q   <= StWrReq;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= StRdAddr;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                StWrReq: begin
                    if (M2_AXI4_AWREADY) awvalid_q <= 1'b0;
                    if (M2_AXI4_WREADY)  wvalid_q  <= 1'b0;
                    if (aw_clear && w_clear) begin
                        state_q  <= StWrResp;
                        bready_q <= 1'b1;
                    end
                end
                StWrResp: begin
                    if (M2_AXI4_BVALID) begin
                        state_q      <= StDone;
                        bready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= (M2_AXI4_BRESP != 2'b00) | (M2_AXI4_BID != IdVal);
                        resp_rdata_q <= '0;
                    end
                end
                StRdAddr: begin
                    if (M2_AXI4_ARREADY) begin
                        state_q   <= StRdData;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                StRdData: begin
                    if (M2_AXI4_RVALID) begin
                        state_q      <= StDone;
                        rready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= M2_AXI4_RDATA;
                        resp_err_q   <= (M2_AXI4_RRESP != 2'b00) | ~M2_AXI4_RLAST
                                        | (M2_AXI4_RID != IdVal);
                    end
                end
                StDone: begin
                    state_q      <= StIdle;
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    assign M2_AXI4_AWID    = IdVal;
    assign M2_AXI4_AWADDR  = addr_q;
    assign M2_AXI4_AWLEN   = 8'd0;
    assign M2_AXI4_AWSIZE  = 3'b010;
    assign M2_AXI4_AWBURST = 2'b01;
    assign M2_AXI4_AWVALID = awvalid_q;

    assign M2_AXI4_WDATA   = wdata_q;
    assign M2_AXI4_WSTRB   = wstrb_q;
    assign M2_AXI4_WLAST   = 1'b1;
    assign M2_AXI4_WVALID  = wvalid_q;

    assign M2_AXI4_BREADY  = bready_q;

    assign M2_AXI4_ARID    = IdVal;
    assign M2_AXI4_ARADDR  = addr_q;
    assign M2_AXI4_ARLEN   = 8'd0;
    assign M2_AXI4_ARSIZE  = 3'b010;
    assign M2_AXI4_ARBURST = 2'b01;
    assign M2_AXI4_ARVALID = arvalid_q;

    assign M2_AXI4_RREADY  = rready_q;

endmodule

// File: tb/tb_cpu_axi4_bridge.sv
// Testbench for cpu_axi4_bridge: randomized CPU requests against a programmable
// AXI4 slave; expected completions are queued at issue time and checked by an
// independent monitor whenever resp_valid is seen.
module tb_cpu_axi4_bridge;

    localparam int IDW    = 4;
    localparam int AXI_ID = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic [IDW-1:0] M2_AXI4_AWID, M2_AXI4_BID, M2_AXI4_ARID, M2_AXI4_RID;
    logic [31:0] M2_AXI4_AWADDR, M2_AXI4_WDATA, M2_AXI4_ARADDR, M2_AXI4_RDATA;
    logic [7:0]  M2_AXI4_AWLEN, M2_AXI4_ARLEN;
    logic [2:0]  M2_AXI4_AWSIZE, M2_AXI4_ARSIZE;
    logic [1:0]  M2_AXI4_AWBURST, M2_AXI4_ARBURST, M2_AXI4_BRESP, M2_AXI4_RRESP;
    logic [3:0]  M2_AXI4_WSTRB;
    logic        M2_AXI4_AWVALID, M2_AXI4_AWREADY, M2_AXI4_WLAST, M2_AXI4_WVALID;
    logic        M2_AXI4_WREADY, M2_AXI4_BVALID, M2_AXI4_BREADY, M2_AXI4_ARVALID;
    logic        M2_AXI4_ARREADY, M2_AXI4_RLAST, M2_AXI4_RVALID, M2_AXI4_RREADY;

    always #5 clk = ~clk;

    cpu_axi4_bridge #(
        .AXI4_ID_WIDTH(IDW),
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .AXI_ID       (AXI_ID)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .M2_AXI4_AWID(M2_AXI4_AWID), .M2_AXI4_AWADDR(M2_AXI4_AWADDR),
        .M2_AXI4_AWLEN(M2_AXI4_AWLEN), .M2_AXI4_AWSIZE(M2_AXI4_AWSIZE),
        .M2_AXI4_AWBURST(M2_AXI4_AWBURST), .M2_AXI4_AWVALID(M2_AXI4_AWVALID),
        .M2_AXI4_AWREADY(M2_AXI4_AWREADY),
        .M2_AXI4_WDATA(M2_AXI4_WDATA), .M2_AXI4_WSTRB(M2_AXI4_WSTRB),
        .M2_AXI4_WLAST(M2_AXI4_WLAST), .M2_AXI4_WVALID(M2_AXI4_WVALID),
        .M2_AXI4_WREADY(M2_AXI4_WREADY),
        .M2_AXI4_BID(M2_AXI4_BID), .M2_AXI4_BRESP(M2_AXI4_BRESP),
        .M2_AXI4_BVALID(M2_AXI4_BVALID), .M2_AXI4_BREADY(M2_AXI4_BREADY),
        .M2_AXI4_ARID(M2_AXI4_ARID), .M2_AXI4_ARADDR(M2_AXI4_ARADDR),
        .M2_AXI4_ARLEN(M2_AXI4_ARLEN), .M2_AXI4_ARSIZE(M2_AXI4_ARSIZE),
        .M2_AXI4_ARBURST(M2_AXI4_ARBURST), .M2_AXI4_ARVALID(M2_AXI4_ARVALID),
        .M2_AXI4_ARREADY(M2_AXI4_ARREADY),
        .M2_AXI4_RID(M2_AXI4_RID), .M2_AXI4_RDATA(M2_AXI4_RDATA),
        .M2_AXI4_RRESP(M2_AXI4_RRESP), .M2_AXI4_RLAST(M2_AXI4_RLAST),
        .M2_AXI4_RVALID(M2_AXI4_RVALID), .M2_AXI4_RREADY(M2_AXI4_RREADY)
    );

    // One transaction: the CPU request plus how the slave will behave for it.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [1:0]  bresp, rresp;
        logic [3:0]  bid, rid;
        logic        rlast;
        logic [31:0] rdata;
    } cfg_t;

    // lat_mode: 0 no latency check, 1 exactly 3 cycles, 2 at most 2 cycles
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        chk_rd;
        int          acc;
        int          lat_mode;
    } exp_t;

    cfg_t cfgq[$];
    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference rules for a completion.
    function automatic exp_t model(input cfg_t c, input int acc, input int lat_mode);
        exp_t e;
        e.acc      = acc;
        e.lat_mode = lat_mode;
        if (c.addr[1:0] != 2'b00) begin
            e.err = 1'b1; e.rdata = 32'h0; e.chk_rd = 1'b1; e.lat_mode = 2;
        end else if (c.we) begin
            e.err = (c.bresp != 2'b00) || (c.bid != 4'(AXI_ID));
            e.rdata = 32'h0; e.chk_rd = 1'b0;
        end else begin
            e.err = (c.rresp != 2'b00) || !c.rlast || (c.rid != 4'(AXI_ID));
            e.rdata = c.rdata; e.chk_rd = 1'b1;
        end
        return e;
    endfunction

    function automatic cfg_t mk(input logic we, input logic [31:0] addr, input logic [31:0] d);
        cfg_t c;
        c.we = we; c.addr = addr; c.wdata = d; c.wstrb = 4'hF;
        c.aw_dly = 0; c.w_dly = 0; c.b_dly = 0; c.ar_dly = 0; c.r_dly = 0;
        c.bresp = 2'b00; c.rresp = 2'b00; c.bid = 4'(AXI_ID); c.rid = 4'(AXI_ID);
        c.rlast = 1'b1; c.rdata = d;
        return c;
    endfunction

    task automatic issue(input cfg_t c, input logic track, input int lat_mode);
        int n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = c.we; req_addr = c.addr;
        req_wdata = c.wdata; req_wstrb = c.wstrb;
        if (c.addr[1:0] == 2'b00) cfgq.push_back(c);
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        e = model(c, cyc, lat_mode);
        if (track) expq.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (c.addr[1:0] != 2'b00) begin
            for (int i = 0; i < 2; i++) begin
                chk("misaligned_no_axvalid", {M2_AXI4_AWVALID, M2_AXI4_WVALID, M2_AXI4_ARVALID}, 0);
                @(negedge clk);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {M2_AXI4_AWVALID, M2_AXI4_WVALID, M2_AXI4_ARVALID, M2_AXI4_BREADY,
                   M2_AXI4_RREADY, resp_valid, resp_err, busy, req_ready}, 0);
        chk({name, "_rdata"}, resp_rdata, 0);
    endtask

    // AXI4 slave: follows the per-transaction script popped from cfgq and checks payload.
    cfg_t cur;
    logic have = 1'b0;
    logic aw_done, w_done, ar_done, aw_p, w_p, b_p, ar_p, r_p;
    int   aw_c, w_c, b_c, ar_c, r_c;

    initial begin
        M2_AXI4_AWREADY = 0; M2_AXI4_WREADY = 0; M2_AXI4_ARREADY = 0;
        M2_AXI4_BVALID = 0; M2_AXI4_RVALID = 0; M2_AXI4_BID = 0; M2_AXI4_BRESP = 0;
        M2_AXI4_RID = 0; M2_AXI4_RDATA = 0; M2_AXI4_RRESP = 0; M2_AXI4_RLAST = 0;
        aw_p = 0; w_p = 0; b_p = 0; ar_p = 0; r_p = 0;
        aw_done = 0; w_done = 0; ar_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                M2_AXI4_AWREADY = 0; M2_AXI4_WREADY = 0; M2_AXI4_ARREADY = 0;
                M2_AXI4_BVALID = 0; M2_AXI4_RVALID = 0;
                have = 0; aw_p = 0; w_p = 0; b_p = 0; ar_p = 0; r_p = 0;
                cfgq.delete();
                continue;
            end
            // Retire handshakes that happened on the last rising edge.
            if (aw_p) begin
                aw_p = 0; aw_done = 1; M2_AXI4_AWREADY = 0;
                chk("awvalid_drop", M2_AXI4_AWVALID, 0);
            end
            if (w_p) begin
                w_p = 0; w_done = 1; M2_AXI4_WREADY = 0;
                chk("wvalid_drop", M2_AXI4_WVALID, 0);
            end
            if (ar_p) begin
                ar_p = 0; ar_done = 1; M2_AXI4_ARREADY = 0;
                chk("arvalid_drop", M2_AXI4_ARVALID, 0);
            end
            if (b_p) begin b_p = 0; M2_AXI4_BVALID = 0; have = 0; end
            if (r_p) begin r_p = 0; M2_AXI4_RVALID = 0; have = 0; end

            if (!have && (M2_AXI4_AWVALID || M2_AXI4_WVALID || M2_AXI4_ARVALID)) begin
                if (cfgq.size() == 0) begin
                    chk("unexpected_axvalid",
                        {M2_AXI4_AWVALID, M2_AXI4_WVALID, M2_AXI4_ARVALID}, 0);
                end else begin
                    cur = cfgq.pop_front();
                    have = 1; aw_done = 0; w_done = 0; ar_done = 0;
                    aw_c = cur.aw_dly; w_c = cur.w_dly; b_c = cur.b_dly;
                    ar_c = cur.ar_dly; r_c = cur.r_dly;
                end
            end

            if (have && cur.we) begin
                chk("arvalid_on_write", M2_AXI4_ARVALID, 0);
                if (!aw_done) begin
                    chk("awvalid_hold", M2_AXI4_AWVALID, 1);
                    if (aw_c == 0) begin
                        M2_AXI4_AWREADY = 1; aw_p = 1;
                        chk("aw_addr", M2_AXI4_AWADDR, cur.addr);
                        chk("aw_ctl", {M2_AXI4_AWID, M2_AXI4_AWLEN, M2_AXI4_AWSIZE,
                                       M2_AXI4_AWBURST}, {4'(AXI_ID), 8'd0, 3'b010, 2'b01});
                    end else aw_c--;
                end
                if (!w_done) begin
                    chk("wvalid_hold", M2_AXI4_WVALID, 1);
                    if (w_c == 0) begin
                        M2_AXI4_WREADY = 1; w_p = 1;
                        chk("w_data", M2_AXI4_WDATA, cur.wdata);
                        chk("w_strb_last", {M2_AXI4_WSTRB, M2_AXI4_WLAST}, {cur.wstrb, 1'b1});
                    end else w_c--;
                end
                if (aw_done && w_done && !M2_AXI4_BVALID) begin
                    if (b_c == 0) begin
                        M2_AXI4_BVALID = 1; M2_AXI4_BID = cur.bid; M2_AXI4_BRESP = cur.bresp;
                    end else b_c--;
                end
                if (M2_AXI4_BVALID && M2_AXI4_BREADY) b_p = 1;
            end else if (have) begin
                chk("awvalid_on_read", {M2_AXI4_AWVALID, M2_AXI4_WVALID}, 0);
                if (!ar_done) begin
                    chk("arvalid_hold", M2_AXI4_ARVALID, 1);
                    if (ar_c == 0) begin
                        M2_AXI4_ARREADY = 1; ar_p = 1;
                        chk("ar_addr", M2_AXI4_ARADDR, cur.addr);
                        chk("ar_ctl", {M2_AXI4_ARID, M2_AXI4_ARLEN, M2_AXI4_ARSIZE,
                                       M2_AXI4_ARBURST}, {4'(AXI_ID), 8'd0, 3'b010, 2'b01});
                    end else ar_c--;
                end else if (!M2_AXI4_RVALID) begin
                    if (r_c == 0) begin
                        M2_AXI4_RVALID = 1; M2_AXI4_RDATA = cur.rdata; M2_AXI4_RID = cur.rid;
                        M2_AXI4_RRESP = cur.rresp; M2_AXI4_RLAST = cur.rlast;
                    end else r_c--;
                end
                if (M2_AXI4_RVALID && M2_AXI4_RREADY) r_p = 1;
            end
        end
    end

    // Monitor: pops the scoreboard on every completion pulse.
    logic        prev_rv = 0;
    logic        last_err = 0;
    logic [31:0] last_rdata = 0;
    logic        rd_known = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rv = 0; last_err = 0; last_rdata = 0; rd_known = 1;
                continue;
            end
            if (resp_valid) begin
                if (prev_rv) chk("resp_valid_one_cycle", resp_valid, 0);
                if (expq.size() == 0) begin
                    chk("unexpected_resp", resp_valid, 0);
                end else begin
                    e = expq.pop_front();
                    chk("resp_err", resp_err, e.err);
                    if (e.chk_rd) chk("resp_rdata", resp_rdata, e.rdata);
                    if (e.lat_mode == 1) chk("latency", cyc - e.acc, 3);
                    if (e.lat_mode == 2) chk("latency_le2", (cyc - e.acc) <= 2, 1);
                    last_err = e.err; last_rdata = e.rdata; rd_known = e.chk_rd;
                end
            end else begin
                chk("resp_err_hold", resp_err, last_err);
                if (rd_known) chk("resp_rdata_hold", resp_rdata, last_rdata);
            end
            prev_rv = resp_valid;
        end
    end

    initial begin
        cfg_t c;
        int   n;
        logic zw;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", {req_ready, busy}, 2'b10);

        // Basic aligned write and read, zero-wait slave.
        issue(mk(1'b1, 32'h1000, 32'hDEADBEEF), 1'b1, 1);
        c = mk(1'b0, 32'h1000, 32'hDEADBEEF);
        issue(c, 1'b1, 1);
        // W accepted 4 cycles after AW.
        c = mk(1'b1, 32'h2004, 32'h12345678); c.w_dly = 4; c.wstrb = 4'h5;
        issue(c, 1'b1, 0);
        // Error responses.
        c = mk(1'b0, 32'h3000, 32'hA5A5A5A5); c.rresp = 2'b10; issue(c, 1'b1, 1);
        c = mk(1'b0, 32'h3004, 32'h5A5A5A5A); c.rid = 4'd5; issue(c, 1'b1, 1);
        c = mk(1'b1, 32'h3008, 32'h0BADF00D); c.bresp = 2'b11; issue(c, 1'b1, 1);
        c = mk(1'b0, 32'h300C, 32'h01020304); c.rlast = 1'b0; issue(c, 1'b1, 1);
        // Misaligned request.
        issue(mk(1'b0, 32'h1002, 32'hFFFFFFFF), 1'b1, 2);
        issue(mk(1'b1, 32'h1001, 32'hFFFFFFFF), 1'b1, 2);

        // Reset while AWVALID is up, then a normal read.
        c = mk(1'b1, 32'h4000, 32'hCAFEF00D); c.aw_dly = 8; c.w_dly = 8;
        issue(c, 1'b0, 0);
        n = 0;
        while (!M2_AXI4_AWVALID && n < 10) begin @(negedge clk); n++; end
        chk("awvalid_before_reset", M2_AXI4_AWVALID, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_write");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(mk(1'b0, 32'h4000, 32'h600DD00D), 1'b1, 1);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            c.we = 1'($urandom_range(0, 1));
            c.addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) c.addr[1:0] = 2'($urandom_range(1, 3));
            c.wdata = $urandom; c.wstrb = 4'($urandom); c.rdata = $urandom;
            zw = ($urandom_range(0, 2) == 0);
            c.aw_dly = zw ? 0 : $urandom_range(0, 3);
            c.w_dly  = zw ? 0 : $urandom_range(0, 3);
            c.b_dly  = zw ? 0 : $urandom_range(0, 3);
            c.ar_dly = zw ? 0 : $urandom_range(0, 3);
            c.r_dly  = zw ? 0 : $urandom_range(0, 3);
            c.bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            c.rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            c.bid = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'(AXI_ID);
            c.rid = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'(AXI_ID);
            c.rlast = ($urandom_range(0, 5) != 0);
            issue(c, 1'b1, zw ? 1 : 0);
        end

        n = 0;
        while ((expq.size() != 0 || !req_ready) && n < 300) begin @(negedge clk); n++; end
        chk("drain_pending", expq.size(), 0);
        chk("final_idle", {req_ready, busy}, 2'b10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
